// File: rtl/mmio_pkg.sv
// Shared register map, FSM state type and STATUS bit layout for the MMIO simulation console.
package mmio_pkg;

  // Register select taken from byte-offset bits [4:3]
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_TOHOST = 2'd2;
  localparam logic [1:0] OFF_CYCLE  = 2'd3;

  localparam int unsigned WINDOW_BYTES = 32;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} console_state_t;

  localparam int unsigned ST_FULL         = 0;
  localparam int unsigned ST_EMPTY        = 1;
  localparam int unsigned ST_OVERFLOW     = 2;
  localparam int unsigned ST_HALT_PENDING = 3;
  localparam int unsigned ST_COUNT_LSB    = 8;
  localparam int unsigned ST_COUNT_W      = 8;

endpackage

// File: rtl/mmio_sim_console_if.sv
// Data-memory port plus console stream and exit signals between the core/bench and the console.
interface mmio_sim_console_if;
  logic        mem_we;
  logic        mem_re;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mmio_hit;
  logic [63:0] mmio_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halt;
  logic [31:0] exit_code;

  modport master (
    output mem_we, mem_re, mem_addr, mem_wdata, tx_ready,
    input  mmio_hit, mmio_rdata, tx_valid, tx_data, halt, exit_code
  );

  modport slave (
    input  mem_we, mem_re, mem_addr, mem_wdata, tx_ready,
    output mmio_hit, mmio_rdata, tx_valid, tx_data, halt, exit_code
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO without fall-through; a push while full is accepted only if a pop frees a slot.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     drop_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && !do_push;

  always_comb begin
    rptr_d  = rptr_q + AW'(do_pop);
    wptr_d  = wptr_q + AW'(do_push);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/mmio_sim_console.sv
// MMIO console: address decode, TX FIFO feed, tohost exit FSM and free-running cycle counter.
module mmio_sim_console
  import mmio_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_1000_0000,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  mmio_sim_console_if.slave   bus
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  console_state_t state_q;
  logic [31:0]    exit_q;
  logic [63:0]    cycle_q;
  logic           ovf_q;

  logic [63:0]    offset, status;
  logic [1:0]     sel;
  logic           wr, rd, push, pop, tohost_wr, drained;
  logic           full, empty, drop;
  logic [CW-1:0]  count;
  logic           unused;

  assign offset       = bus.mem_addr - BASE_ADDR;
  assign bus.mmio_hit = (offset < 64'(WINDOW_BYTES));
  assign sel          = offset[4:3];
  assign wr           = bus.mmio_hit && bus.mem_we;
  assign rd           = bus.mmio_hit && bus.mem_re && !bus.mem_we;

  assign push      = wr && (sel == OFF_TXDATA) && (state_q == RUN);
  assign pop       = bus.tx_valid && bus.tx_ready;
  assign tohost_wr = wr && (sel == OFF_TOHOST) && bus.mem_wdata[0] && (state_q == RUN);
  // No push can coincide with a TOHOST write or DRAIN, so only a final pop can empty the FIFO here
  assign drained   = empty || ((count == CW'(1)) && pop);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (bus.mem_wdata[7:0]),
    .rdata_o (bus.tx_data),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty),
    .drop_o  (drop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      exit_q  <= '0;
      cycle_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (drop) ovf_q <= 1'b1;
      case (state_q)
        RUN: if (tohost_wr) begin
          exit_q  <= {1'b0, bus.mem_wdata[31:1]};
          state_q <= drained ? HALTED : DRAIN;
        end
        DRAIN:   if (drained) state_q <= HALTED;
        HALTED:  state_q <= HALTED;
        default: state_q <= RUN;
      endcase
    end
  end

  always_comb begin
    status                                = '0;
    status[ST_FULL]                       = full;
    status[ST_EMPTY]                      = empty;
    status[ST_OVERFLOW]                   = ovf_q;
    status[ST_HALT_PENDING]               = (state_q == DRAIN);
    status[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(count);
  end

  always_comb begin
    bus.mmio_rdata = '0;
    if (rd) begin
      case (sel)
        OFF_STATUS: bus.mmio_rdata = status;
        OFF_TOHOST: bus.mmio_rdata = {32'b0, exit_q};
        OFF_CYCLE:  bus.mmio_rdata = cycle_q;
        default:    bus.mmio_rdata = '0;
      endcase
    end
  end

  assign bus.tx_valid  = !empty;
  assign bus.halt      = (state_q == HALTED);
  assign bus.exit_code = exit_q;
  assign unused        = ^bus.mem_wdata[63:32];
endmodule

// File: tb/tb_mmio_sim_console.sv
// Directed bench for mmio_sim_console: queue-based reference model checked every cycle plus literal checks.
module tb_mmio_sim_console;
  localparam logic [63:0] BASE  = 64'h0000_0000_1000_0000;
  localparam int          DEPTH = 16;
  localparam logic [63:0] A_TX  = BASE;
  localparam logic [63:0] A_ST  = BASE + 64'd8;
  localparam logic [63:0] A_TH  = BASE + 64'd16;
  localparam logic [63:0] A_CY  = BASE + 64'd24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mmio_sim_console_if bus();

  mmio_sim_console #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: byte queue plus flags for draining / halted
  logic [7:0]  mq[$];
  logic        m_ovf, m_drain, m_halt;
  logic [31:0] m_exit;
  logic [63:0] m_cyc;
  bit          m_live = 0;
  logic [7:0]  log_q[$];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_hit();
    return (bus.mem_addr >= BASE) && (bus.mem_addr < BASE + 64'd32);
  endfunction

  function automatic logic [1:0] m_off();
    logic [63:0] o;
    o = bus.mem_addr - BASE;
    return o[4:3];
  endfunction

  function automatic logic [63:0] m_rdata();
    logic [63:0] st;
    int n;
    n = mq.size();
    st = 64'(n == DEPTH) | (64'(n == 0) << 1) | (64'(m_ovf) << 2) | (64'(m_drain) << 3) | (64'(n) << 8);
    if (!(m_hit() && bus.mem_re && !bus.mem_we)) return 64'd0;
    case (m_off())
      2'd1:    return st;
      2'd2:    return {32'd0, m_exit};
      2'd3:    return m_cyc;
      default: return 64'd0;
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        check64("mmio_hit", {63'd0, bus.mmio_hit}, {63'd0, m_hit()});
        check64("mmio_rdata", bus.mmio_rdata, m_rdata());
        check64("tx_valid", {63'd0, bus.tx_valid}, {63'd0, mq.size() > 0});
        if (mq.size() > 0) check64("tx_data", {56'd0, bus.tx_data}, {56'd0, mq[0]});
        check64("halt", {63'd0, bus.halt}, {63'd0, m_halt});
        check64("exit_code", {32'd0, bus.exit_code}, {32'd0, m_exit});
        if (bus.tx_valid && bus.tx_ready) log_q.push_back(bus.tx_data);
      end
      if (rst) begin
        mq.delete();
        m_ovf = 0; m_drain = 0; m_halt = 0; m_exit = '0; m_cyc = '0;
        m_live = 1;
      end else if (m_live) begin
        if (mq.size() > 0 && bus.tx_ready) void'(mq.pop_front());
        if (m_hit() && bus.mem_we && m_off() == 2'd0 && !m_drain && !m_halt) begin
          if (mq.size() < DEPTH) mq.push_back(bus.mem_wdata[7:0]);
          else m_ovf = 1;
        end
        if (m_drain) begin
          if (mq.size() == 0) begin m_drain = 0; m_halt = 1; end
        end else if (!m_halt && m_hit() && bus.mem_we && m_off() == 2'd2 && bus.mem_wdata[0]) begin
          m_exit = {1'b0, bus.mem_wdata[31:1]};
          if (mq.size() == 0) m_halt = 1;
          else m_drain = 1;
        end
        m_cyc = m_cyc + 64'd1;
      end
    end
  end

  task automatic clk1();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.mem_we = 0; bus.mem_re = 0; bus.mem_addr = '0; bus.mem_wdata = '0;
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d);
    bus.mem_we = 1; bus.mem_re = 0; bus.mem_addr = a; bus.mem_wdata = d;
    clk1();
    idle();
  endtask

  task automatic load(input logic [63:0] a, output logic [63:0] v);
    bus.mem_we = 0; bus.mem_re = 1; bus.mem_addr = a;
    @(negedge clk); #1;
    v = bus.mmio_rdata;
    clk1();
    idle();
  endtask

  task automatic do_reset();
    rst = 1; idle();
    clk1();
    rst = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] v, c1;
    int k;
    rst = 1; bus.tx_ready = 1; idle();
    repeat (2) clk1();
    rst = 0;

    // Reset state and first-cycle counter value
    check64("rst_tx_valid", {63'd0, bus.tx_valid}, 64'd0);
    check64("rst_halt", {63'd0, bus.halt}, 64'd0);
    check64("rst_exit", {32'd0, bus.exit_code}, 64'd0);
    load(A_CY, v);
    check64("cycle_first", v, 64'd0);

    // Two bytes streamed with ready high
    store(A_TX, 64'h48);
    bus.mem_we = 1; bus.mem_addr = A_TX; bus.mem_wdata = 64'h69;
    @(negedge clk); #1;
    check64("byte0", {55'd0, bus.tx_valid, bus.tx_data}, 64'h148);
    clk1(); idle();
    @(negedge clk); #1;
    check64("byte1", {55'd0, bus.tx_valid, bus.tx_data}, 64'h169);
    clk1();
    load(A_ST, v);
    check64("status_idle", v, 64'h2);

    // Overflow: 17 pushes into 16 slots
    bus.tx_ready = 0;
    for (int i = 0; i < 17; i++) store(A_TX, 64'(i));
    load(A_ST, v);
    check64("status_ovf", v, 64'h1005);
    log_q.delete();
    bus.tx_ready = 1;
    repeat (20) clk1();
    check64("ovf_count", 64'(log_q.size()), 64'd16);
    for (int i = 0; i < 16 && i < log_q.size(); i++) check64("ovf_byte", {56'd0, log_q[i]}, 64'(i));

    // Full with simultaneous push and pop
    do_reset();
    bus.tx_ready = 0;
    for (int i = 0; i < 16; i++) store(A_TX, 64'h20 + 64'(i));
    log_q.delete();
    bus.tx_ready = 1;
    store(A_TX, 64'hAA);
    bus.tx_ready = 0;
    load(A_ST, v);
    check64("status_full_pp", v, 64'h1001);
    bus.tx_ready = 1;
    repeat (20) clk1();
    check64("pp_count", 64'(log_q.size()), 64'd17);
    if (log_q.size() == 17) begin
      check64("pp_first", {56'd0, log_q[0]}, 64'h20);
      check64("pp_last", {56'd0, log_q[16]}, 64'hAA);
    end

    // Drain before halt
    do_reset();
    bus.tx_ready = 0;
    store(A_TX, 64'h1); store(A_TX, 64'h2); store(A_TX, 64'h3);
    store(A_TH, 64'h1);
    check64("drain_halt0", {63'd0, bus.halt}, 64'd0);
    check64("drain_exit", {32'd0, bus.exit_code}, 64'd0);
    load(A_ST, v);
    check64("status_drain", v, 64'h308);
    store(A_TX, 64'h55);
    load(A_ST, v);
    check64("status_drain_ign", v, 64'h308);
    log_q.delete();
    bus.tx_ready = 1;
    k = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (bus.halt) begin k = i; break; end
    end
    check64("halt_latency", 64'(k), 64'd3);
    check64("drain_pops", 64'(log_q.size()), 64'd3);
    clk1();

    // Immediate halt with empty FIFO; zero TOHOST ignored
    do_reset();
    store(A_TH, 64'h0);
    check64("tohost0_halt", {63'd0, bus.halt}, 64'd0);
    load(A_ST, v);
    check64("tohost0_status", v, 64'h2);
    store(A_TH, 64'h7);
    check64("exit_halt", {63'd0, bus.halt}, 64'd1);
    check64("exit_code3", {32'd0, bus.exit_code}, 64'd3);
    load(A_TH, v);
    check64("tohost_read", v, 64'd3);
    store(A_TX, 64'h77);
    check64("halted_no_push", {63'd0, bus.tx_valid}, 64'd0);

    // Cycle counter delta, then reset mid-drain
    do_reset();
    load(A_CY, c1);
    repeat (4) clk1();
    load(A_CY, v);
    check64("cycle_delta", v - c1, 64'd5);
    bus.tx_ready = 0;
    store(A_TX, 64'hC1); store(A_TX, 64'hC2);
    store(A_TH, 64'h5);
    check64("pre_rst_exit", {32'd0, bus.exit_code}, 64'd2);
    do_reset();
    check64("post_rst_halt", {63'd0, bus.halt}, 64'd0);
    check64("post_rst_valid", {63'd0, bus.tx_valid}, 64'd0);
    check64("post_rst_exit", {32'd0, bus.exit_code}, 64'd0);
    load(A_CY, v);
    check64("post_rst_cycle", v, 64'd0);
    load(A_ST, v);
    check64("post_rst_status", v, 64'h2);

    repeat (2) clk1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
